// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Two-stage pipelined ALU with valid/ready handshakes on both sides.
//   The opcode map is invert-A / invert-B followed by a 3-bit function.
//   Status is {V,C,N,Z}. A user tag travels with each operation.
//   ovf_sticky records any delivered result that had V=1.
//
//   Stage 1 registers the operands, carry-in, select and tag.
//   Stage 2 registers the result, status and tag. out_valid is the
//   stage-2 valid bit.
//
// Optional feature (macro ALU_MUL_EN):
//   defined   -> function 7 is the low WIDTH bits of A'*B' (unsigned).
//                Partial products are registered with stage 1 and summed
//                ahead of stage 2, so latency is unchanged.
//   undefined -> function 7 returns 0 with status Z. No multiplier is built.
//
// Parameters:
//   WIDTH  operand/result width (power of two, >= 8)
//   TAG_W  user tag width
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake
//   a, b, cin, sel       operands, adder carry-in,
//                        sel = {inv_a, inv_b, function[2:0]}
//   tag_in               tag accepted with the operation
//   out_valid/out_ready  output handshake
//   f, status, tag_out   result, {V,C,N,Z}, tag of the result
//   ovf_sticky, ovf_clr  sticky overflow flag and its clear
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [4:0]       sel,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [3:0]       status,
  output logic [TAG_W-1:0] tag_out,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] FN_XOR = 3'd0;
  localparam logic [2:0] FN_AND = 3'd1;
  localparam logic [2:0] FN_OR  = 3'd2;
  localparam logic [2:0] FN_NOR = 3'd3;
  localparam logic [2:0] FN_ADD = 3'd4;
  localparam logic [2:0] FN_SLL = 3'd5;
  localparam logic [2:0] FN_SRL = 3'd6;
  localparam logic [2:0] FN_MUL = 3'd7;

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [4:0]       s1_sel;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;

  logic             s1_load;
  logic             s1_adv;
  logic             deliver;

  // Stage 1 can take a new op whenever its current content can move on
  // this cycle. That happens when stage 2 is empty or is draining. This
  // keeps the pipe bubble-free, and in_ready depends combinationally on
  // out_ready.
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign s1_load   = in_valid && in_ready;
  assign s1_adv    = s1_valid && (!s2_valid || out_ready);
  assign deliver   = s2_valid && out_ready;
  assign out_valid = s2_valid;

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_sel   <= '0;
      s1_tag   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_cin   <= cin;
        s1_sel   <= sel;
        s1_tag   <= tag_in;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_MUL_EN
  // ---------------------------------------------------------------------------
  // Multiplier, split across the two stages.
  // Only the low WIDTH bits of the product are needed. With H = WIDTH/2:
  //   A'*B' mod 2^W = lo*lo + ((lo_a*hi_b + hi_a*lo_b) mod 2^H) << H
  // The three partial products are formed from the inputs and registered
  // with stage 1. The final sum feeds stage 2.
  // ---------------------------------------------------------------------------
  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] in_ap;
  logic [WIDTH-1:0] in_bp;
  logic [WIDTH-1:0] pp_ll_d;
  logic [HALF-1:0]  pp_lh_d;
  logic [HALF-1:0]  pp_hl_d;
  logic [WIDTH-1:0] s1_pp_ll;
  logic [HALF-1:0]  s1_pp_lh;
  logic [HALF-1:0]  s1_pp_hl;
  logic [WIDTH-1:0] mul_f;

  assign in_ap   = sel[4] ? ~a : a;
  assign in_bp   = sel[3] ? ~b : b;
  assign pp_ll_d = {{HALF{1'b0}}, in_ap[HALF-1:0]} * {{HALF{1'b0}}, in_bp[HALF-1:0]};
  assign pp_lh_d = in_ap[HALF-1:0] * in_bp[WIDTH-1:HALF];
  assign pp_hl_d = in_ap[WIDTH-1:HALF] * in_bp[HALF-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_pp_ll <= '0;
      s1_pp_lh <= '0;
      s1_pp_hl <= '0;
    end else if (s1_load) begin
      s1_pp_ll <= pp_ll_d;
      s1_pp_lh <= pp_lh_d;
      s1_pp_hl <= pp_hl_d;
    end
  end

  assign mul_f = s1_pp_ll + {s1_pp_lh + s1_pp_hl, {HALF{1'b0}}};
`endif

  // ---------------------------------------------------------------------------
  // Stage 1 -> stage 2 combinational datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] ap;
  logic [WIDTH-1:0] bp;
  logic [WIDTH:0]   sum;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] f_d;
  logic             c_d;
  logic             v_d;
  logic [3:0]       status_d;

  assign ap    = s1_sel[4] ? ~s1_a : s1_a;
  assign bp    = s1_sel[3] ? ~s1_b : s1_b;
  assign sum   = {1'b0, ap} + {1'b0, bp} + {{WIDTH{1'b0}}, s1_cin};
  // Shift amount ignores b bits above SH_W-1; shifts use raw a, not A'.
  assign shamt = s1_b[SH_W-1:0];

  always_comb begin
    f_d = '0;
    c_d = 1'b0;
    v_d = 1'b0;
    case (s1_sel[2:0])
      FN_XOR: f_d = ap ^ bp;
      FN_AND: f_d = ap & bp;
      FN_OR:  f_d = ap | bp;
      FN_NOR: f_d = ~(ap | bp);
      FN_ADD: begin
        f_d = sum[WIDTH-1:0];
        c_d = sum[WIDTH];
        // Signed overflow: operands agree in sign, result does not.
        v_d = ~(ap[WIDTH-1] ^ bp[WIDTH-1]) & (sum[WIDTH-1] ^ ap[WIDTH-1]);
      end
      FN_SLL: f_d = s1_a << shamt;
      FN_SRL: f_d = s1_a >> shamt;
`ifdef ALU_MUL_EN
      FN_MUL: f_d = mul_f;
`else
      FN_MUL: f_d = '0;
`endif
      default: f_d = '0;
    endcase
    status_d = {v_d, c_d, f_d[WIDTH-1], (f_d == '0)};
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (visible outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      f        <= '0;
      status   <= 4'b0001;
      tag_out  <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        f        <= f_d;
        status   <= status_d;
        tag_out  <= s1_tag;
      end else if (deliver) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // A setting delivery takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (deliver && status[3]) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe (WIDTH=32, TAG_W=4).
module tb_alu_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [4:0]  sel;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f;
  logic [3:0]  status;
  logic [3:0]  tag_out;
  logic        ovf_sticky;
  logic        ovf_clr;

  int tests_run;
  int tests_failed;

  alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sel(sel), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .status(status), .tag_out(tag_out),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op with out_ready=1 and return the delivered result.
  // Ends 1 time unit after the edge that delivered the result.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic [4:0] ts, input logic [3:0] tt,
                        output logic [31:0] rf, output logic [3:0] rs,
                        output logic [3:0] rt);
    int k;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; sel = ts; tag_in = tt;
    in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    if (!out_valid) begin
      tests_run++; tests_failed++;
      $display("FAIL run_op_timeout tag=%0h out_valid=%b required 1", tt, out_valid);
    end
    rf = f; rs = status; rt = tag_out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    a = '0; b = '0; cin = 1'b0; sel = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests_run++; if (f !== 32'h0) begin tests_failed++; $display("FAIL reset_f got=%h exp=0", f); end
    tests_run++; if (status !== 4'b0001) begin tests_failed++; $display("FAIL reset_status got=%b exp=0001", status); end
    tests_run++; if (tag_out !== 4'h0) begin tests_failed++; $display("FAIL reset_tag got=%h exp=0", tag_out); end
    tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got=%b exp=0", ovf_sticky); end
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    a = 32'd2; b = 32'd3; cin = 1'b0; sel = 5'h04; tag_in = 4'h9;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_edge1 out_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_edge2 out_valid got=%b exp=1", out_valid); end
    tests_run++; if (f !== 32'd5 || tag_out !== 4'h9) begin tests_failed++; $display("FAIL lat_result f=%h tag=%h exp f=5 tag=9", f, tag_out); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_drain out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_alu();
    // {a, b, cin, sel, expected f, expected status {V,C,N,Z}}
    logic [105:0] vec [19];
    logic [31:0]  ta, tb, ef, rf;
    logic         tc;
    logic [4:0]   ts;
    logic [3:0]   es, rs, rt;
    vec[0]  = {32'h7FFFFFFF, 32'h00000001, 1'b0, 5'h04, 32'h80000000, 4'b1010};
    vec[1]  = {32'h00000005, 32'h00000005, 1'b1, 5'h0C, 32'h00000000, 4'b0101};
    vec[2]  = {32'h00000003, 32'h00000005, 1'b1, 5'h0C, 32'hFFFFFFFE, 4'b0010};
    vec[3]  = {32'h80000001, 32'h00000021, 1'b0, 5'h05, 32'h00000002, 4'b0000};
    vec[4]  = {32'h80000001, 32'h0000001F, 1'b0, 5'h06, 32'h00000001, 4'b0000};
    vec[5]  = {32'h12345678, 32'h00000020, 1'b0, 5'h05, 32'h12345678, 4'b0000};
    vec[6]  = {32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 5'h00, 32'h0FF00FF0, 4'b0000};
    vec[7]  = {32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 5'h01, 32'hF000F000, 4'b0010};
    vec[8]  = {32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 5'h02, 32'hFFF0FFF0, 4'b0010};
    vec[9]  = {32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 5'h03, 32'h000F000F, 4'b0000};
    vec[10] = {32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 5'h11, 32'h0F000F00, 4'b0000};
    vec[11] = {32'hFFFFFFFF, 32'h00000001, 1'b0, 5'h04, 32'h00000000, 4'b0101};
    vec[12] = {32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 5'h00, 32'h00000000, 4'b0001};
    vec[13] = {32'h80000000, 32'h80000000, 1'b0, 5'h04, 32'h00000000, 4'b1101};
    vec[14] = {32'h00000001, 32'h00000000, 1'b1, 5'h14, 32'hFFFFFFFF, 4'b0010};
    vec[15] = {32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'h00, 32'h0FF00FF0, 4'b0000};
    vec[16] = {32'h00000001, 32'h00000004, 1'b0, 5'h15, 32'h00000010, 4'b0000};
    vec[17] = {32'h80000000, 32'h00000004, 1'b0, 5'h06, 32'h08000000, 4'b0000};
    vec[18] = {32'h00000000, 32'h00000000, 1'b0, 5'h03, 32'hFFFFFFFF, 4'b0010};
    for (int i = 0; i < 19; i++) begin
      {ta, tb, tc, ts, ef, es} = vec[i];
      run_op(ta, tb, tc, ts, 4'(i), rf, rs, rt);
      tests_run++;
      if (rf !== ef || rs !== es || rt !== 4'(i)) begin
        tests_failed++;
        $display("FAIL alu_vec%0d f=%h status=%b tag=%h exp f=%h status=%b tag=%h",
                 i, rf, rs, rt, ef, es, 4'(i));
      end
    end
  endtask

  task automatic test_ovf();
    logic [31:0] rf;
    logic [3:0]  rs, rt;
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got=%b exp=0", ovf_sticky); end
    run_op(32'd10, 32'd20, 1'b0, 5'h04, 4'h1, rf, rs, rt);
    tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("FAIL ovf_noset got=%b exp=0", ovf_sticky); end
    run_op(32'h7FFFFFFF, 32'h1, 1'b0, 5'h04, 4'h2, rf, rs, rt);
    tests_run++; if (ovf_sticky !== 1'b1 || rs !== 4'b1010) begin tests_failed++; $display("FAIL ovf_set got=%b status=%b exp=1 status=1010", ovf_sticky, rs); end
    run_op(32'h1, 32'h1, 1'b0, 5'h00, 4'h3, rf, rs, rt);
    tests_run++; if (ovf_sticky !== 1'b1) begin tests_failed++; $display("FAIL ovf_hold got=%b exp=1", ovf_sticky); end
    // clear held across an overflowing delivery: set wins on that edge
    ovf_clr = 1'b1;
    run_op(32'h80000000, 32'h80000000, 1'b0, 5'h04, 4'h4, rf, rs, rt);
    tests_run++; if (ovf_sticky !== 1'b1) begin tests_failed++; $display("FAIL ovf_set_wins got=%b exp=1", ovf_sticky); end
    run_op(32'h1, 32'h2, 1'b0, 5'h04, 4'h5, rf, rs, rt);
    tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("FAIL ovf_clr_nodeliver got=%b exp=0", ovf_sticky); end
    ovf_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] rtag [8];
    int         rcyc [8];
    int         n;
    n = 0;
    out_ready = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c < 4) begin
        in_valid = 1'b1; a = 32'(c); b = 32'h100; cin = 1'b0; sel = 5'h04; tag_in = 4'(8 + c);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 4) begin
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      if (out_valid && n < 8) begin
        rtag[n] = tag_out; rcyc[n] = c; n++;
      end
      @(posedge clk);
    end
    #1;
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      tests_run++;
      if (rtag[i] !== 4'(8 + i) || rcyc[i] !== i + 2) begin
        tests_failed++;
        $display("FAIL b2b_item%0d tag=%h cyc=%0d exp tag=%h cyc=%0d", i, rtag[i], rcyc[i], 4'(8 + i), i + 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  rtag [8];
    logic [31:0] rf [8];
    int          n, nt;
    logic        acc;
    n = 0;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd0; b = 32'h10; cin = 1'b0; sel = 5'h04; tag_in = 4'd0;
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_accept0 in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    a = 32'd1; tag_in = 4'd1;
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_accept1 in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    a = 32'd2; tag_in = 4'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || tag_out !== 4'd0 || f !== 32'h10) begin
        tests_failed++;
        $display("FAIL bp_stall c=%0d in_ready=%b out_valid=%b tag=%h f=%h exp 0 1 0 00000010",
                 c, in_ready, out_valid, tag_out, f);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    nt = 2;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (out_valid && n < 8) begin
        rtag[n] = tag_out; rf[n] = f; n++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        nt++;
        if (nt < 4) begin a = 32'(nt); tag_in = 4'(nt); end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL bp_count got=%0d exp=4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      tests_run++;
      if (rtag[i] !== 4'(i) || rf[i] !== 32'h10 + 32'(i)) begin
        tests_failed++;
        $display("FAIL bp_item%0d tag=%h f=%h exp tag=%h f=%h", i, rtag[i], rf[i], 4'(i), 32'h10 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] rf;
    logic [3:0]  rs, rt;
    run_op(32'h7FFFFFFF, 32'h1, 1'b0, 5'h04, 4'hE, rf, rs, rt);
    tests_run++; if (ovf_sticky !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre_ovf got=%b exp=1", ovf_sticky); end
    out_ready = 1'b0; in_valid = 1'b1;
    a = 32'h7FFFFFFF; b = 32'h1; cin = 1'b0; sel = 5'h04; tag_in = 4'h6;
    @(posedge clk); #1;
    tag_in = 4'h7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || status !== 4'b0001 || ovf_sticky !== 1'b0 || in_ready !== 1'b1 || f !== 32'h0 || tag_out !== 4'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_state out_valid=%b status=%b ovf=%b in_ready=%b f=%h tag=%h exp 0 0001 0 1 0 0",
               out_valid, status, ovf_sticky, in_ready, f, tag_out);
    end
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_discard out_valid=%b exp=0", out_valid); end
    end
    run_op(32'd40, 32'd2, 1'b0, 5'h04, 4'hA, rf, rs, rt);
    tests_run++;
    if (rf !== 32'd42 || rs !== 4'b0000 || rt !== 4'hA || ovf_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_after f=%h status=%b tag=%h ovf=%b exp 0000002a 0000 a 0", rf, rs, rt, ovf_sticky);
    end
  endtask

  task automatic test_func7();
    logic [31:0] rf;
    logic [3:0]  rs, rt;
    logic [31:0] e0, e1, e2;
    logic [3:0]  s0, s1, s2;
`ifdef ALU_MUL_EN
    e0 = 32'hFFFFFFFF; s0 = 4'b0010;
    e1 = 32'h0000000F; s1 = 4'b0000;
    e2 = 32'h00000007; s2 = 4'b0000;
`else
    e0 = 32'h0; s0 = 4'b0001;
    e1 = 32'h0; s1 = 4'b0001;
    e2 = 32'h0; s2 = 4'b0001;
`endif
    run_op(32'h0000FFFF, 32'h00010001, 1'b0, 5'h07, 4'h1, rf, rs, rt);
    tests_run++; if (rf !== e0 || rs !== s0) begin tests_failed++; $display("FAIL fn7_a f=%h status=%b exp f=%h status=%b", rf, rs, e0, s0); end
    run_op(32'd3, 32'd5, 1'b1, 5'h07, 4'h2, rf, rs, rt);
    tests_run++; if (rf !== e1 || rs !== s1) begin tests_failed++; $display("FAIL fn7_b f=%h status=%b exp f=%h status=%b", rf, rs, e1, s1); end
    run_op(32'hFFFFFFFE, 32'd7, 1'b0, 5'h17, 4'h3, rf, rs, rt);
    tests_run++; if (rf !== e2 || rs !== s2) begin tests_failed++; $display("FAIL fn7_inv f=%h status=%b exp f=%h status=%b", rf, rs, e2, s2); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_latency();
    test_alu();
    test_ovf();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_func7();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached without completion");
    $fatal(1);
  end

endmodule
